// File: rtl/regbench_pkg.sv
// rtl/regbench_pkg.sv - shared widths, protected addresses and helpers for the register bench
package regbench_pkg;

  localparam int REG_ADDR_W    = 5;
  localparam int REG_DATA_W    = 32;
  localparam int N_REQ_DEFAULT = 3;

  localparam logic [REG_ADDR_W-1:0] REG_ZERO  = 5'd0;
  localparam logic [REG_ADDR_W-1:0] REG_CONST = 5'd1;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [REG_DATA_W-1:0] data;
  } wr_req_t;

  function automatic logic is_protected(input logic [REG_ADDR_W-1:0] addr);
    return (addr == REG_ZERO) || (addr == REG_CONST);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin arbiter, search starts at ptr
module rr_arbiter #(
  parameter int N  = 3,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx
);

  logic found;
  int   idx;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = 0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(ptr) + k) % N;
      if (!found && req[idx]) begin
        found        = 1'b1;
        gnt[idx]     = 1'b1;
        gnt_idx      = IW'(idx);
      end
    end
  end

endmodule

// File: rtl/regbench_write_arbiter.sv
// rtl/regbench_write_arbiter.sv - shares the register bench write port among requesters
module regbench_write_arbiter
  import regbench_pkg::*;
#(
  parameter int N_REQ      = N_REQ_DEFAULT,
  parameter int DROP_CNT_W = 8
) (
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic                         stall,
  input  logic [N_REQ-1:0]             req_valid,
  input  logic [N_REQ*REG_ADDR_W-1:0]  req_addr,
  input  logic [N_REQ*REG_DATA_W-1:0]  req_data,
  output logic [N_REQ-1:0]             req_ready,
  output logic                         wr_en,
  output logic [REG_ADDR_W-1:0]        wr_addr,
  output logic [REG_DATA_W-1:0]        wr_data,
  output logic [31:0]                  pending,
  output logic                         drop_pulse,
  output logic [DROP_CNT_W-1:0]        drop_count
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [IW-1:0]         rr_ptr_q, rr_ptr_d;
  logic [IW-1:0]         gnt_idx;
  logic [N_REQ-1:0]      gnt;
  logic                  hs;
  logic                  drop_hit;
  wr_req_t               sel;

  logic                  wr_en_q, wr_en_d;
  logic [REG_ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [REG_DATA_W-1:0] wr_data_q, wr_data_d;
  logic                  drop_pulse_q, drop_pulse_d;
  logic [DROP_CNT_W-1:0] drop_count_q, drop_count_d;

  rr_arbiter #(.N(N_REQ), .IW(IW)) u_arb (
    .req     (req_valid),
    .ptr     (rr_ptr_q),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  // Grant is suppressed under stall or reset so no handshake can slip through.
  assign req_ready = (stall || !reset_n) ? '0 : gnt;
  assign hs        = |(req_valid & req_ready);

  always_comb begin
    sel = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (gnt[i]) begin
        sel.addr = req_addr[i*REG_ADDR_W +: REG_ADDR_W];
        sel.data = req_data[i*REG_DATA_W +: REG_DATA_W];
      end
    end
  end

  assign drop_hit = hs && is_protected(sel.addr);

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (hs) begin
      rr_ptr_d = (gnt_idx == IW'(N_REQ - 1)) ? '0 : gnt_idx + 1'b1;
    end
  end

  // Dropped writes leave addr/data untouched so the bench sees a stable bus.
  always_comb begin
    wr_en_d      = hs && !drop_hit;
    wr_addr_d    = wr_en_d ? sel.addr : wr_addr_q;
    wr_data_d    = wr_en_d ? sel.data : wr_data_q;
    drop_pulse_d = drop_hit;
    drop_count_d = drop_count_q;
    if (drop_hit && (drop_count_q != '1)) begin
      drop_count_d = drop_count_q + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr_q     <= '0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      drop_pulse_q <= 1'b0;
      drop_count_q <= '0;
    end else begin
      rr_ptr_q     <= rr_ptr_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      drop_pulse_q <= drop_pulse_d;
      drop_count_q <= drop_count_d;
    end
  end

  assign wr_en      = wr_en_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign pending    = wr_en_q ? (32'd1 << wr_addr_q) : 32'd0;
  assign drop_pulse = drop_pulse_q;
  assign drop_count = drop_count_q;

endmodule

// File: tb/tb_regbench_write_arbiter.sv
// tb/tb_regbench_write_arbiter.sv - vector table plus scoreboard bench for the write arbiter
module tb_regbench_write_arbiter;

  logic        clock;
  logic        reset_n;
  logic        stall;
  logic [2:0]  req_valid;
  logic [14:0] req_addr;
  logic [95:0] req_data;
  logic [2:0]  req_ready;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic [31:0] pending;
  logic        drop_pulse;
  logic [7:0]  drop_count;

  regbench_write_arbiter #(.N_REQ(3), .DROP_CNT_W(8)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .stall      (stall),
    .req_valid  (req_valid),
    .req_addr   (req_addr),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .pending    (pending),
    .drop_pulse (drop_pulse),
    .drop_count (drop_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic        stall;
    logic [2:0]  valid;
    logic [14:0] addr;
    logic [95:0] data;
    logic [2:0]  exp_ready;
  } vec_t;

  typedef struct {
    logic        en;
    logic [4:0]  addr;
    logic [31:0] data;
    logic        drop;
  } exp_out_t;

  vec_t       tbl[$];
  exp_out_t   sb[$];
  int         n_applied = 0;
  int         n_err = 0;
  int         exp_cnt = 0;
  logic [4:0]  last_addr = '0;
  logic [31:0] last_data = '0;

  function automatic vec_t mk(input logic s, input logic [2:0] v,
                              input logic [4:0] a0, input logic [4:0] a1, input logic [4:0] a2,
                              input logic [31:0] d0, input logic [31:0] d1, input logic [31:0] d2,
                              input logic [2:0] er);
    vec_t r;
    r.stall     = s;
    r.valid     = v;
    r.addr      = {a2, a1, a0};
    r.data      = {d2, d1, d0};
    r.exp_ready = er;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected output stage derived from the table's expected grant.
  task automatic model_push(input vec_t v);
    exp_out_t e;
    int idx;
    logic [4:0]  a;
    logic [31:0] d;
    idx = -1;
    for (int i = 0; i < 3; i++) if (v.exp_ready[i]) idx = i;
    e.en = 1'b0; e.drop = 1'b0; e.addr = last_addr; e.data = last_data;
    if (idx >= 0) begin
      a = v.addr[idx*5 +: 5];
      d = v.data[idx*32 +: 32];
      if (a < 5'd2) begin
        e.drop = 1'b1;
        if (exp_cnt != 255) exp_cnt++;
      end else begin
        e.en = 1'b1; e.addr = a; e.data = d;
        last_addr = a; last_data = d;
      end
    end
    sb.push_back(e);
  endtask

  task automatic apply_vec(input vec_t v);
    exp_out_t e;
    stall     = v.stall;
    req_valid = v.valid;
    req_addr  = v.addr;
    req_data  = v.data;
    #1;
    n_applied++;
    chk("req_ready", 32'(req_ready), 32'(v.exp_ready));
    model_push(v);
    @(posedge clock);
    #1;
    if (sb.size() == 0) begin
      n_err++;
      $display("FAIL scoreboard: empty queue");
    end else begin
      e = sb.pop_front();
      chk("wr_en", 32'(wr_en), 32'(e.en));
      chk("wr_addr", 32'(wr_addr), 32'(e.addr));
      chk("wr_data", wr_data, e.data);
      chk("pending", pending, e.en ? (32'd1 << e.addr) : 32'd0);
      chk("drop_pulse", 32'(drop_pulse), 32'(e.drop));
      chk("drop_count", 32'(drop_count), 32'(exp_cnt));
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Round-robin contention from rr_ptr = 0.
    tbl.push_back(mk(0, 3'b111, 4, 5, 6, 32'hA, 32'hB, 32'hC, 3'b001));
    tbl.push_back(mk(0, 3'b111, 4, 5, 6, 32'hA, 32'hB, 32'hC, 3'b010));
    tbl.push_back(mk(0, 3'b111, 4, 5, 6, 32'hA, 32'hB, 32'hC, 3'b100));
    tbl.push_back(mk(0, 3'b000, 0, 0, 0, 0, 0, 0, 3'b000));
    // Single write from requester 1.
    tbl.push_back(mk(0, 3'b010, 0, 7, 0, 0, 32'hDEADBEEF, 0, 3'b010));
    tbl.push_back(mk(0, 3'b000, 0, 0, 0, 0, 0, 0, 3'b000));
    // Protected addresses are granted but dropped.
    tbl.push_back(mk(0, 3'b001, 0, 0, 0, 32'h11, 0, 0, 3'b001));
    tbl.push_back(mk(0, 3'b001, 1, 0, 0, 32'h22, 0, 0, 3'b001));
    tbl.push_back(mk(0, 3'b000, 0, 0, 0, 0, 0, 0, 3'b000));
    // Stall holds off requester 2 for three cycles.
    tbl.push_back(mk(1, 3'b100, 0, 0, 9, 0, 0, 32'h99, 3'b000));
    tbl.push_back(mk(1, 3'b100, 0, 0, 9, 0, 0, 32'h99, 3'b000));
    tbl.push_back(mk(1, 3'b100, 0, 0, 9, 0, 0, 32'h99, 3'b000));
    tbl.push_back(mk(0, 3'b100, 0, 0, 9, 0, 0, 32'h99, 3'b100));
    // Wrap-around and back-to-back grants; stall does not cancel the output stage.
    tbl.push_back(mk(0, 3'b101, 12, 0, 13, 32'h1200, 0, 32'h1300, 3'b001));
    tbl.push_back(mk(1, 3'b100, 0, 0, 13, 0, 0, 32'h1300, 3'b000));
    tbl.push_back(mk(0, 3'b110, 0, 14, 13, 0, 32'h1400, 32'h1300, 3'b010));
    tbl.push_back(mk(0, 3'b100, 0, 0, 13, 0, 0, 32'h1300, 3'b100));
    tbl.push_back(mk(0, 3'b011, 2, 31, 0, 32'h0202, 32'h3131, 0, 3'b001));
    tbl.push_back(mk(0, 3'b010, 0, 31, 0, 0, 32'h3131, 0, 3'b010));
    tbl.push_back(mk(0, 3'b000, 0, 0, 0, 0, 0, 0, 3'b000));

    reset_n   = 1'b0;
    stall     = 1'b0;
    req_valid = 3'b111;
    req_addr  = '0;
    req_data  = '0;
    repeat (3) @(posedge clock);
    #1;
    n_applied++;
    chk("reset req_ready", 32'(req_ready), 32'd0);
    chk("reset wr_en", 32'(wr_en), 32'd0);
    chk("reset wr_addr", 32'(wr_addr), 32'd0);
    chk("reset wr_data", wr_data, 32'd0);
    chk("reset pending", pending, 32'd0);
    chk("reset drop_pulse", 32'(drop_pulse), 32'd0);
    chk("reset drop_count", 32'(drop_count), 32'd0);
    req_valid = 3'b000;
    reset_n   = 1'b1;
    @(posedge clock);
    #1;

    for (int i = 0; i < tbl.size(); i++) apply_vec(tbl[i]);

    // Drop-counter saturation with a lone requester hammering register 0.
    for (int i = 0; i < 300; i++) apply_vec(mk(0, 3'b001, 0, 0, 0, i, 0, 0, 3'b001));
    n_applied++;
    chk("drop_count saturated", 32'(drop_count), 32'd255);
    apply_vec(mk(0, 3'b000, 0, 0, 0, 0, 0, 0, 3'b000));

    // Reset mid-stream while a write sits in the output stage.
    apply_vec(mk(0, 3'b100, 0, 0, 20, 0, 0, 32'h2020, 3'b100));
    req_valid = 3'b111;
    req_addr  = {5'd4, 5'd3, 5'd2};
    req_data  = {32'hC4, 32'hC3, 32'hC2};
    reset_n   = 1'b0;
    #1;
    n_applied++;
    chk("midreset wr_en", 32'(wr_en), 32'd0);
    chk("midreset pending", 32'(pending), 32'd0);
    chk("midreset drop_count", 32'(drop_count), 32'd0);
    chk("midreset req_ready", 32'(req_ready), 32'd0);
    @(posedge clock);
    #1;
    chk("held reset req_ready", 32'(req_ready), 32'd0);
    reset_n   = 1'b1;
    exp_cnt   = 0;
    last_addr = '0;
    last_data = '0;
    sb.delete();
    // rr_ptr must be back at 0, so requester 0 wins first.
    apply_vec(mk(0, 3'b111, 2, 3, 4, 32'hC2, 32'hC3, 32'hC4, 3'b001));
    apply_vec(mk(0, 3'b000, 0, 0, 0, 0, 0, 0, 3'b000));

    $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_err);
    $finish;
  end

endmodule
